// File: rtl/core_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : core_wb_sched
// Brief    : Register-reservation scoreboard and round-robin writeback
//            arbiter.
//            Decode reserves destinations through the issue port and is
//            stalled on RAW/WAW hazards. NUM_REQ writeback requesters compete
//            for a single register-file write port. Each grant is written one
//            cycle later, and that write releases the reservation.
// Ports    : clk_i, rst_n_i             clock, asynchronous active-low reset
//            issue_valid_i/rd_i/ready_o reservation request and accept
//            rs0_addr_i, rs1_addr_i     decode source operands
//            hazard_o                   decode stall
//            wb_valid_i/rd_i/data_i     per-requester writeback request
//            wb_ready_o                 one-hot writeback grant
//            rd_we_o/addr_o/data_o      registered register-file write port
//            pend_cnt_o, idle_o         reservation count / none pending
//            err_o                      sticky: writeback to unreserved reg
// Revision : 1.0 - initial release
// ============================================================================
module core_wb_sched #(
    parameter int NUM_REQ = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  issue_valid_i,
    input  logic [4:0]            issue_rd_i,
    output logic                  issue_ready_o,
    input  logic [4:0]            rs0_addr_i,
    input  logic [4:0]            rs1_addr_i,
    output logic                  hazard_o,
    input  logic [NUM_REQ-1:0]    wb_valid_i,
    input  logic [NUM_REQ*5-1:0]  wb_rd_i,
    input  logic [NUM_REQ*32-1:0] wb_data_i,
    output logic [NUM_REQ-1:0]    wb_ready_o,
    output logic                  rd_we_o,
    output logic [4:0]            rd_addr_o,
    output logic [31:0]           rd_data_o,
    output logic [5:0]            pend_cnt_o,
    output logic                  idle_o,
    output logic                  err_o
);

    localparam logic [2:0] c_num_req = 3'(NUM_REQ);

    // Registered state
    logic [31:0] r_busy;
    logic [1:0]  r_ptr;
    logic        r_err;
    logic [5:0]  r_cnt;
    logic        r_we;
    logic [4:0]  r_addr;
    logic [31:0] r_data;

    // Requester inputs padded to four slots so that the arbiter can use a
    // fixed 2-bit index whatever NUM_REQ is.
    logic [3:0]  w_valid_pad;
    logic [4:0]  w_rd_pad   [4];
    logic [31:0] w_data_pad [4];

    generate
        for (genvar k = 0; k < 4; k++) begin : g_pad
            if (k < NUM_REQ) begin : g_used
                assign w_valid_pad[k] = wb_valid_i[k];
                assign w_rd_pad[k]    = wb_rd_i[5*k +: 5];
                assign w_data_pad[k]  = wb_data_i[32*k +: 32];
            end else begin : g_unused
                assign w_valid_pad[k] = 1'b0;
                assign w_rd_pad[k]    = 5'd0;
                assign w_data_pad[k]  = 32'd0;
            end
        end
    endgenerate

    // Round-robin search starting at r_ptr
    logic       w_gnt_valid;
    logic [1:0] w_gnt_idx;
    logic [2:0] w_scan;

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = 2'd0;
        w_scan      = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, r_ptr} + 3'(i);
            if (w_scan >= c_num_req) begin
                w_scan = w_scan - c_num_req;
            end
            if (!w_gnt_valid && w_valid_pad[w_scan[1:0]]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_scan[1:0];
            end
        end
        // No grant is visible while reset is held
        if (!rst_n_i) begin
            w_gnt_valid = 1'b0;
        end
    end

    logic [3:0]  w_grant_pad;
    logic [4:0]  w_gnt_rd;
    logic [31:0] w_gnt_data;
    logic [2:0]  w_ptr_inc;
    logic [1:0]  w_ptr_nxt;

    assign w_grant_pad = w_gnt_valid ? (4'b0001 << w_gnt_idx) : 4'b0000;
    assign w_gnt_rd    = w_rd_pad[w_gnt_idx];
    assign w_gnt_data  = w_data_pad[w_gnt_idx];
    assign w_ptr_inc   = {1'b0, w_gnt_idx} + 3'd1;
    assign w_ptr_nxt   = (w_ptr_inc >= c_num_req) ? 2'd0 : w_ptr_inc[1:0];

    // Issue / hazard
    logic w_issue_ready;
    logic w_set;
    logic w_clr;
    logic w_err_hit;

    assign w_issue_ready = rst_n_i && issue_valid_i &&
                           ((issue_rd_i == 5'd0) || !r_busy[issue_rd_i]);
    assign w_set         = w_issue_ready && (issue_rd_i != 5'd0);
    // A write to a register that was never reserved releases nothing; gating
    // on r_busy keeps the counter equal to the population of r_busy.
    assign w_clr         = r_we && r_busy[r_addr];
    // A register being released on this edge counts as no longer reserved.
    assign w_err_hit     = w_gnt_valid && (w_gnt_rd != 5'd0) &&
                           !(r_busy[w_gnt_rd] && !(r_we && (r_addr == w_gnt_rd)));

    logic [31:0] w_busy_nxt;
    logic [5:0]  w_cnt_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_clr) begin
            w_busy_nxt[r_addr] = 1'b0;
        end
        // Cannot collide with the clear: a busy register is never accepted.
        if (w_set) begin
            w_busy_nxt[issue_rd_i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_set, w_clr})
            2'b10:   w_cnt_nxt = r_cnt + 6'd1;
            2'b01:   w_cnt_nxt = r_cnt - 6'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_busy <= 32'd0;
            r_ptr  <= 2'd0;
            r_err  <= 1'b0;
            r_cnt  <= 6'd0;
            r_we   <= 1'b0;
            r_addr <= 5'd0;
            r_data <= 32'd0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
            r_we   <= w_gnt_valid && (w_gnt_rd != 5'd0);
            if (w_err_hit) begin
                r_err <= 1'b1;
            end
            if (w_gnt_valid) begin
                r_ptr  <= w_ptr_nxt;
                r_addr <= w_gnt_rd;
                r_data <= w_gnt_data;
            end
        end
    end

    assign issue_ready_o = w_issue_ready;
    assign hazard_o      = ((rs0_addr_i != 5'd0) && r_busy[rs0_addr_i]) ||
                           ((rs1_addr_i != 5'd0) && r_busy[rs1_addr_i]) ||
                           (issue_valid_i && !w_issue_ready);
    assign wb_ready_o    = w_grant_pad[NUM_REQ-1:0];
    assign rd_we_o       = r_we;
    assign rd_addr_o     = r_addr;
    assign rd_data_o     = r_data;
    assign pend_cnt_o    = r_cnt;
    assign idle_o        = (r_cnt == 6'd0);
    assign err_o         = r_err;

endmodule
`default_nettype wire
